// File: rtl/match_window_counter.sv
// Counts rising edges of the detector match flag over programmable back-to-back
// windows, reporting the final count and a threshold alarm at each window end.
module match_window_counter #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             y,
  input  logic [WIN_W-1:0] win_len,
  input  logic [CNT_W-1:0] thresh,
  output logic [CNT_W-1:0] live_count,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  output logic             alarm,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic [WIN_W-1:0] timer, timer_nxt, win_eff;
  logic [CNT_W-1:0] live_nxt, live_inc, cnt_nxt;
  logic             cv_nxt, alarm_nxt, y_q, ev;

  assign ev       = y & ~y_q;
  assign win_eff  = (win_len == '0) ? WIN_W'(1) : win_len;
  // Saturating increment: sticks at all-ones instead of wrapping.
  assign live_inc = (ev && live_count != CNT_MAX) ? live_count + CNT_W'(1) : live_count;

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    live_nxt  = live_count;
    cnt_nxt   = count_out;
    alarm_nxt = alarm;
    cv_nxt    = 1'b0;
    case (state)
      IDLE: begin
        live_nxt = '0;
        if (en) begin
          state_nxt = RUN;
          timer_nxt = win_eff;
        end
      end
      RUN: begin
        if (!en) begin
          state_nxt = IDLE;
          timer_nxt = '0;
          live_nxt  = '0;
        end else begin
          live_nxt  = live_inc;
          timer_nxt = timer - WIN_W'(1);
          if (timer == WIN_W'(1)) begin
            state_nxt = REPORT;
            cnt_nxt   = live_inc;
            alarm_nxt = (live_inc >= thresh);
            cv_nxt    = 1'b1;
          end
        end
      end
      REPORT: begin
        if (en) begin
          state_nxt = RUN;
          timer_nxt = win_eff;
          // An edge seen during the report cycle opens the next window's count.
          live_nxt  = CNT_W'(ev);
        end else begin
          state_nxt = IDLE;
          live_nxt  = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
        live_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      y_q         <= 1'b0;
      live_count  <= '0;
      count_out   <= '0;
      count_valid <= 1'b0;
      alarm       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      y_q         <= y;
      live_count  <= live_nxt;
      count_out   <= cnt_nxt;
      count_valid <= cv_nxt;
      alarm       <= alarm_nxt;
      busy        <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_match_window_counter.sv
// Bench for match_window_counter (CNT_W=4, WIN_W=8): vector table plus
// hand-built window sequences, all checked through an expected-value queue.
module tb_match_window_counter;

  logic       clk = 1'b0;
  logic       rst, en, y;
  logic [7:0] win_len;
  logic [3:0] thresh;
  logic [3:0] live_count, count_out;
  logic       count_valid, alarm, busy;

  match_window_counter #(.CNT_W(4), .WIN_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .y(y), .win_len(win_len), .thresh(thresh),
    .live_count(live_count), .count_out(count_out), .count_valid(count_valid),
    .alarm(alarm), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] live, cnt;
    logic       cv, al, bz;
  } exp_t;

  typedef struct {
    logic       rst, en, y;
    logic [7:0] wl;
    logic [3:0] th;
    int         live, cnt;
    logic       cv, al, bz;
  } vec_t;

  exp_t sb[$];
  vec_t vt[10];
  int   checks = 0;
  int   errors = 0;
  int   last_cnt = 0;
  logic last_al = 1'b0;

  task automatic set_in(input logic r, input logic e, input logic yy);
    rst = r; en = e; y = yy;
  endtask

  // Queue the expected post-edge outputs, clock once, then pop and compare.
  task automatic cyc(input string nm, input int l, input int c,
                     input logic v, input logic a, input logic b);
    exp_t e;
    e.name = nm; e.live = 4'(l); e.cnt = 4'(c); e.cv = v; e.al = a; e.bz = b;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (live_count !== e.live || count_out !== e.cnt || count_valid !== e.cv ||
        alarm !== e.al || busy !== e.bz) begin
      errors++;
      $display("FAIL %s: got live=%0d cnt=%0d cv=%b alarm=%b busy=%b, want live=%0d cnt=%0d cv=%b alarm=%b busy=%b",
               e.name, live_count, count_out, count_valid, alarm, busy,
               e.live, e.cnt, e.cv, e.al, e.bz);
    end
  endtask

  // One full window from IDLE; ymask bit k drives y in RUN cycle k+1.
  task automatic run_window(input string nm, input int wl, input int th,
                            input logic [63:0] ymask, input int exp_cnt, input logic exp_al);
    int   ev_n;
    int   sat;
    logic prev_y;
    win_len = 8'(wl); thresh = 4'(th);
    set_in(1'b0, 1'b1, 1'b0);
    cyc({nm, "_entry"}, 0, last_cnt, 1'b0, last_al, 1'b1);
    ev_n = 0; prev_y = 1'b0;
    for (int k = 0; k < wl; k++) begin
      y = ymask[k];
      if (y && !prev_y) ev_n++;
      prev_y = y;
      sat = (ev_n > 15) ? 15 : ev_n;
      if (k < wl - 1)
        cyc($sformatf("%s_run%0d", nm, k + 1), sat, last_cnt, 1'b0, last_al, 1'b1);
      else
        cyc({nm, "_report"}, sat, exp_cnt, 1'b1, exp_al, 1'b1);
    end
    set_in(1'b0, 1'b0, 1'b0);
    cyc({nm, "_idle"}, 0, exp_cnt, 1'b0, exp_al, 1'b0);
    last_cnt = exp_cnt; last_al = exp_al;
  endtask

  initial begin
    set_in(1'b1, 1'b1, 1'b1);
    win_len = 8'd2; thresh = 4'd1;

    // rst rst en wl th | live cnt cv alarm busy
    vt[0] = '{1'b1, 1'b1, 1'b1, 8'd2, 4'd1, 0, 0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b1, 1'b1, 1'b1, 8'd2, 4'd1, 0, 0, 1'b0, 1'b0, 1'b0};
    vt[2] = '{1'b0, 1'b1, 1'b1, 8'd2, 4'd1, 0, 0, 1'b0, 1'b0, 1'b1};
    vt[3] = '{1'b0, 1'b1, 1'b0, 8'd2, 4'd1, 0, 0, 1'b0, 1'b0, 1'b1};
    vt[4] = '{1'b0, 1'b1, 1'b1, 8'd2, 4'd1, 1, 1, 1'b1, 1'b1, 1'b1};
    vt[5] = '{1'b0, 1'b1, 1'b1, 8'd2, 4'd1, 0, 1, 1'b0, 1'b1, 1'b1};
    vt[6] = '{1'b0, 1'b1, 1'b0, 8'd2, 4'd1, 0, 1, 1'b0, 1'b1, 1'b1};
    vt[7] = '{1'b0, 1'b1, 1'b0, 8'd2, 4'd1, 0, 0, 1'b1, 1'b0, 1'b1};
    vt[8] = '{1'b0, 1'b0, 1'b0, 8'd2, 4'd1, 0, 0, 1'b0, 1'b0, 1'b0};
    vt[9] = '{1'b0, 1'b0, 1'b0, 8'd2, 4'd1, 0, 0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 10; i++) begin
      set_in(vt[i].rst, vt[i].en, vt[i].y);
      win_len = vt[i].wl; thresh = vt[i].th;
      cyc($sformatf("vec%0d", i), vt[i].live, vt[i].cnt, vt[i].cv, vt[i].al, vt[i].bz);
    end

    run_window("basic_th3", 10, 3, 64'h92, 3, 1'b1);
    run_window("basic_th4", 10, 4, 64'h92, 3, 1'b0);
    run_window("held", 8, 1, 64'h3E, 1, 1'b1);
    run_window("thresh0", 3, 0, 64'h0, 0, 1'b1);
    run_window("sat", 64, 15, 64'h0000_0055_5555_5555, 15, 1'b1);

    // Abort on the 4th RUN cycle of a 10-cycle window.
    win_len = 8'd10; thresh = 4'd3;
    set_in(1'b0, 1'b1, 1'b0); cyc("abort_entry", 0, 15, 1'b0, 1'b1, 1'b1);
    set_in(1'b0, 1'b1, 1'b0); cyc("abort_r1",    0, 15, 1'b0, 1'b1, 1'b1);
    set_in(1'b0, 1'b1, 1'b1); cyc("abort_r2",    1, 15, 1'b0, 1'b1, 1'b1);
    set_in(1'b0, 1'b1, 1'b0); cyc("abort_r3",    1, 15, 1'b0, 1'b1, 1'b1);
    set_in(1'b0, 1'b0, 1'b0); cyc("abort_drop",  0, 15, 1'b0, 1'b1, 1'b0);
    set_in(1'b0, 1'b0, 1'b0); cyc("abort_idle",  0, 15, 1'b0, 1'b1, 1'b0);

    // Reset mid-window discards the window and clears held results.
    win_len = 8'd5;
    set_in(1'b0, 1'b1, 1'b0); cyc("rstmid_entry", 0, 15, 1'b0, 1'b1, 1'b1);
    set_in(1'b0, 1'b1, 1'b1); cyc("rstmid_r1",    1, 15, 1'b0, 1'b1, 1'b1);
    set_in(1'b1, 1'b1, 1'b0); cyc("rstmid_rst",   0, 0, 1'b0, 1'b0, 1'b0);
    set_in(1'b0, 1'b0, 1'b0); cyc("rstmid_idle",  0, 0, 1'b0, 1'b0, 1'b0);

    // win_len=0: single-cycle windows alternating with REPORT.
    win_len = 8'd0; thresh = 4'd1;
    set_in(1'b0, 1'b1, 1'b0); cyc("b2b_entry",   0, 0, 1'b0, 1'b0, 1'b1);
    set_in(1'b0, 1'b1, 1'b1); cyc("b2b_lastrun", 1, 1, 1'b1, 1'b1, 1'b1);
    set_in(1'b0, 1'b1, 1'b0); cyc("b2b_run2",    0, 1, 1'b0, 1'b1, 1'b1);
    set_in(1'b0, 1'b1, 1'b0); cyc("b2b_rep2",    0, 0, 1'b1, 1'b0, 1'b1);
    set_in(1'b0, 1'b1, 1'b1); cyc("b2b_repev",   1, 0, 1'b0, 1'b0, 1'b1);
    set_in(1'b0, 1'b1, 1'b0); cyc("b2b_rep3",    1, 1, 1'b1, 1'b1, 1'b1);
    set_in(1'b0, 1'b0, 1'b0); cyc("b2b_idle",    0, 1, 1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/match_window_counter.md
Name: match_window_counter

Overview:
- Downstream consumer of the serial sequence-detector output `y`.
- Counts distinct match events (rising edges of `y`) within a programmable window of clock cycles.
- At the end of each window: presents the final count for one cycle and a held threshold alarm.
- Runs windows back-to-back while enabled. Sits between the detector FSM and status/interrupt logic.

Parameters:
- CNT_W, 8, width of event counters; counts saturate at 2^CNT_W-1.
- WIN_W, 16, width of the window-length input and internal cycle timer.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  enable; 1 starts/continues windowing, 0 aborts to IDLE.
- y  input  1  match flag from the upstream sequence detector.
- win_len  input  WIN_W  window length in cycles; sampled only at window start; 0 treated as 1.
- thresh  input  CNT_W  alarm threshold; sampled at report time.
- live_count  output  CNT_W  running event count of the current window.
- count_out  output  CNT_W  final count of the last completed window; held until next report.
- count_valid  output  1  one-cycle pulse, count_out updated this cycle.
- alarm  output  1  1 when last completed window count >= thresh; held until next report.
- busy  output  1  1 whenever state is not IDLE.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE; timer=0; y_q=0.
  - live_count, count_out, count_valid, alarm, busy all 0.
  - Reset mid-window discards that window with no report.
- Event detect:
  - y_q registers y every cycle, in all states.
  - ev = y & ~y_q. y held high N cycles yields one event.
  - y=1 on the first cycle after reset is an event.
- States IDLE, RUN, REPORT; all outputs registered.
- IDLE:
  - live_count=0.
  - en=1 -> RUN; timer loaded with max(win_len,1).
  - Events in IDLE are ignored.
- RUN:
  - Each cycle: live_count += ev (saturating); timer -= 1.
  - timer==1 with en=1 -> REPORT, so RUN lasts exactly max(win_len,1) cycles.
  - On the same edge: count_out <= sat(live_count+ev); alarm <= (that value >= thresh); count_valid <= 1.
  - en=0 in any RUN cycle -> IDLE next cycle: no report, live_count cleared, count_out/alarm unchanged.
- REPORT (exactly one cycle):
  - count_valid=1 during this cycle only.
  - en=1 -> RUN; timer reloaded from the current win_len; live_count <= ev, so an event in the REPORT cycle belongs to the next window.
  - en=0 -> IDLE; live_count <= 0.
- Latency: count_valid is asserted in the cycle immediately following the last RUN cycle of a window.
- Saturation: live_count and count_out stick at all-ones and never wrap.
- thresh=0 gives alarm=1 on every report.
- win_len changes mid-window take effect only at the next window start.
- busy=1 in RUN and REPORT.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles with y=1, en=1.
  - Required: all outputs 0 while reset is held; first cycle after release is IDLE; the next is RUN with busy=1.
- Basic window:
  - Stimulus: win_len=10, thresh=3, en=1; three 1-cycle y pulses inside RUN.
  - Required: count_valid high exactly once, 10 cycles after RUN entry; count_out=3; alarm=1.
  - Repeat with thresh=4 -> alarm=0.
- Held level:
  - Stimulus: y high for 5 consecutive RUN cycles, win_len=8.
  - Required: count_out=1; live_count steps 0->1 once.
- Saturation:
  - Stimulus: CNT_W=4, win_len=64, 20 isolated y pulses.
  - Required: live_count stops at 15; count_out=15; no wrap to 0.
- Abort:
  - Stimulus: en dropped at cycle 4 of a win_len=10 window.
  - Required: state IDLE next cycle; busy=0; live_count=0; no count_valid; prior count_out/alarm retained.
- Boundary events:
  - Stimulus: win_len=0 with back-to-back windows; events on the last RUN cycle and on the REPORT cycle.
  - Required: 1-cycle windows alternate with REPORT.
  - The last-RUN-cycle event is included in the current count_out.
  - The REPORT-cycle event appears as live_count=1 in the next window.
